// File: rtl/dtcm_arbiter.sv
// rtl/dtcm_arbiter.sv - two-port DTCM SRAM arbiter with 1-cycle response steering
// Optional macro DTCM_ARB_RR_EN: round-robin on contention instead of fixed priority.
module dtcm_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  input  logic [MW-1:0] p0_req_wem,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  input  logic [MW-1:0] p1_req_wem,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  logic rsp_pend_q, rsp_pend_d;
  logic rsp_port_q, rsp_port_d;
  logic rsp_is_read_q, rsp_is_read_d;
  logic gnt0, gnt1;

`ifdef DTCM_ARB_RR_EN
  logic last_gnt_q, last_gnt_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  // Grant is gated by rst so every output is quiet while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (p0_req_valid && p1_req_valid) begin
`ifdef DTCM_ARB_RR_EN
        if (last_gnt_q) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
`else
        if (starve_cnt_q == STARVE_LIM) gnt1 = 1'b1;
        else                            gnt0 = 1'b1;
`endif
      end else if (p0_req_valid) begin
        gnt0 = 1'b1;
      end else if (p1_req_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_pend_d    = gnt0 | gnt1;
    rsp_port_d    = gnt1;
    rsp_is_read_d = (gnt0 & ~p0_req_we) | (gnt1 & ~p1_req_we);
`ifdef DTCM_ARB_RR_EN
    last_gnt_d = (gnt0 | gnt1) ? gnt1 : last_gnt_q;
`else
    starve_cnt_d = 4'd0;
    if (p1_req_valid && !gnt1) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pend_q    <= 1'b0;
      rsp_port_q    <= 1'b0;
      rsp_is_read_q <= 1'b0;
`ifdef DTCM_ARB_RR_EN
      last_gnt_q    <= 1'b1;
`else
      starve_cnt_q  <= 4'd0;
`endif
    end else begin
      rsp_pend_q    <= rsp_pend_d;
      rsp_port_q    <= rsp_port_d;
      rsp_is_read_q <= rsp_is_read_d;
`ifdef DTCM_ARB_RR_EN
      last_gnt_q    <= last_gnt_d;
`else
      starve_cnt_q  <= starve_cnt_d;
`endif
    end
  end

  always_comb begin
    p0_req_ready = gnt0;
    p1_req_ready = gnt1;
    ram_we   = (gnt0 & p0_req_we) | (gnt1 & p1_req_we);
    ram_addr = '0;
    ram_din  = '0;
    ram_wem  = '0;
    if (gnt0) begin
      ram_addr = p0_req_addr;
      ram_din  = p0_req_wdata;
      ram_wem  = p0_req_wem;
    end else if (gnt1) begin
      ram_addr = p1_req_addr;
      ram_din  = p1_req_wdata;
      ram_wem  = p1_req_wem;
    end
  end

  // Read data is steered only to the port that owns the pending read.
  always_comb begin
    p0_rsp_valid = rsp_pend_q & ~rsp_port_q;
    p1_rsp_valid = rsp_pend_q & rsp_port_q;
    p0_rsp_rdata = (p0_rsp_valid && rsp_is_read_q) ? ram_dout : '0;
    p1_rsp_rdata = (p1_rsp_valid && rsp_is_read_q) ? ram_dout : '0;
  end

endmodule

// File: doc/dtcm_arbiter.md
Name: dtcm_arbiter

Overview:
- Two-port arbiter that shares the single-port DTCM SRAM between the CPU load/store path (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1).
- Sits between the cpu and srams instances in the top level and takes over the dtcm_ram_* bundle.
- Handles valid/ready request handshakes, fixed priority with anti-starvation, and response steering with the SRAM's 1-cycle read latency.

Parameters:
- AW, 16, SRAM word-address width
- DW, 32, data width
- MW, 4, write-enable mask width (DW/8)
- STARVE_MAX, 4, consecutive lost arbitrations before port 1 is forced to win; range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- p0_req_valid  in  1  port 0 request valid
- p0_req_ready  out  1  port 0 request accepted this cycle
- p0_req_we  in  1  1 = write, 0 = read
- p0_req_addr  in  AW  word address
- p0_req_wdata  in  DW  write data
- p0_req_wem  in  MW  byte write mask
- p0_rsp_valid  out  1  port 0 response valid
- p0_rsp_rdata  out  DW  port 0 read data
- p1_req_valid, p1_req_ready, p1_req_we, p1_req_addr, p1_req_wdata, p1_req_wem, p1_rsp_valid, p1_rsp_rdata: as port 0, for port 1
- ram_we  out  1  SRAM write enable
- ram_addr  out  AW  SRAM address
- ram_din  out  DW  SRAM write data
- ram_wem  out  MW  SRAM byte mask
- ram_dout  in  DW  SRAM read data, valid the cycle after the address

Behaviour:
- Grant is combinational from the request valids and the registered arbitration state. At most one req_ready is high per cycle.
- A request is accepted when valid && ready. There is no request-side buffering.
- The SRAM bundle carries the winner's we/addr/wdata/wem in the same cycle as acceptance. With no grant: ram_we=0, ram_wem=0, ram_addr=0, ram_din=0.
- Latency: request accepted in cycle N -> rsp_valid pulses for exactly one cycle in N+1 on the same port, for both reads and writes.
  - Read: rsp_rdata = ram_dout.
  - Write: rsp_rdata = 0.
  - The rsp_rdata of a non-valid port is 0.
- There is no response backpressure; requesters must accept responses. Back-to-back acceptance every cycle is supported, giving full throughput.
- Registered state:
  - rsp_port (1 bit) and rsp_is_read (1 bit), captured at acceptance.
  - rsp_pend (1 bit) = any acceptance last cycle.
  - starve_cnt (4 bits).
  - last_gnt (1 bit), used only with the optional feature.
- Arbitration (default, fixed priority):
  - Only one valid: that port wins.
  - Both valid: port 0 wins, unless starve_cnt == STARVE_MAX, in which case port 1 wins.
- starve_cnt:
  - Increments when p1_req_valid is high and port 1 is not granted.
  - Clears to 0 when port 1 is granted or p1_req_valid is low.
  - Saturates at STARVE_MAX.
- Requesters must hold the request stable while valid && !ready. Changing it is a protocol violation with undefined result.
- Reset asserted, including mid-transfer:
  - All registers clear.
  - Every output is 0: both req_ready, both rsp_valid, both rsp_rdata, and all ram_* outputs.
  - A response pending at reset is dropped and never delivered.
- After reset deasserts, arbitration resumes on the first clk edge with starve_cnt=0 and last_gnt=1, so port 0 is next in round-robin mode.

Optional Feature:
- Macro: DTCM_ARB_RR_EN.
- Defined: round-robin replaces fixed priority. On contention, the port that was not last_gnt wins. last_gnt updates on every acceptance. starve_cnt is not implemented and STARVE_MAX is ignored.
- Undefined: fixed priority with starvation counter, as described under Behaviour.

Test Plan:
- Single read, port 0 only: addr=0x10, preloaded 0xDEADBEEF, accepted cycle N -> p0_rsp_valid=1 with rdata=0xDEADBEEF in N+1; p1 signals stay 0.
- Write then read, port 1: write addr=0x20, wdata=0x12345678, wem=0x3, then read 0x20 over old data 0xFFFFFFFF -> rdata=0xFFFF5678 one cycle after the read is accepted.
- Contention, fixed priority, STARVE_MAX=4: both ports valid continuously -> grant sequence 0,0,0,0,1,0,0,0,0,1; each response appears on the correct port one cycle after its grant.
- Back-to-back reads on port 0 to addrs 1,2,3 in consecutive cycles -> three consecutive rsp_valid cycles with matching data, with no bubbles.
- rst asserted the cycle after a port-1 read is accepted -> p1_rsp_valid stays 0 and all outputs are 0 while rst=1; after release a fresh read completes normally.
- With DTCM_ARB_RR_EN and both ports valid continuously from reset -> grants alternate 0,1,0,1,...
